// File: rtl/lift_pkg.sv
// Shared definitions for the lift hall-call scheduler and the lift FSM:
// request codes, motion outputs, button indices and the scheduler state enum.
package lift_pkg;

    localparam int unsigned NUM_CALLS = 6;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned CODE_W    = 3;
    localparam int unsigned FLOOR_W   = 2;

    localparam logic [CODE_W-1:0] REQ_NONE = 3'b000;
    localparam logic [CODE_W-1:0] REQ_1U   = 3'b001;
    localparam logic [CODE_W-1:0] REQ_2U   = 3'b010;
    localparam logic [CODE_W-1:0] REQ_3U   = 3'b011;
    localparam logic [CODE_W-1:0] REQ_2D   = 3'b110;
    localparam logic [CODE_W-1:0] REQ_3D   = 3'b111;
    localparam logic [CODE_W-1:0] REQ_4D   = 3'b100;

    localparam logic [1:0] STAY = 2'b00;
    localparam logic [1:0] UP   = 2'b01;
    localparam logic [1:0] DOWN = 2'b10;

    localparam int unsigned BTN_1U = 0;
    localparam int unsigned BTN_2U = 1;
    localparam int unsigned BTN_3U = 2;
    localparam int unsigned BTN_2D = 3;
    localparam int unsigned BTN_3D = 4;
    localparam int unsigned BTN_4D = 5;

    localparam logic [NUM_CALLS-1:0] UP_CALLS = 6'b000111;
    localparam logic [NUM_CALLS-1:0] DN_CALLS = 6'b111000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2,
        S_WAIT   = 2'd3
    } sched_state_e;

    // Floor the button is on (0..3 = floors 1..4).
    function automatic logic [FLOOR_W-1:0] call_floor(input logic [IDX_W-1:0] idx);
        case (idx)
            IDX_W'(BTN_1U): call_floor = 2'd0;
            IDX_W'(BTN_2U): call_floor = 2'd1;
            IDX_W'(BTN_3U): call_floor = 2'd2;
            IDX_W'(BTN_2D): call_floor = 2'd1;
            IDX_W'(BTN_3D): call_floor = 2'd2;
            IDX_W'(BTN_4D): call_floor = 2'd3;
            default:        call_floor = 2'd0;
        endcase
    endfunction

    // Floor the lift is heading to once the call is served.
    function automatic logic [FLOOR_W-1:0] call_dest(input logic [IDX_W-1:0] idx);
        case (idx)
            IDX_W'(BTN_1U): call_dest = 2'd1;
            IDX_W'(BTN_2U): call_dest = 2'd2;
            IDX_W'(BTN_3U): call_dest = 2'd3;
            IDX_W'(BTN_2D): call_dest = 2'd0;
            IDX_W'(BTN_3D): call_dest = 2'd1;
            IDX_W'(BTN_4D): call_dest = 2'd2;
            default:        call_dest = 2'd0;
        endcase
    endfunction

    function automatic logic [CODE_W-1:0] call_code(input logic [IDX_W-1:0] idx);
        case (idx)
            IDX_W'(BTN_1U): call_code = REQ_1U;
            IDX_W'(BTN_2U): call_code = REQ_2U;
            IDX_W'(BTN_3U): call_code = REQ_3U;
            IDX_W'(BTN_2D): call_code = REQ_2D;
            IDX_W'(BTN_3D): call_code = REQ_3D;
            IDX_W'(BTN_4D): call_code = REQ_4D;
            default:        call_code = REQ_NONE;
        endcase
    endfunction

    function automatic logic call_is_up(input logic [IDX_W-1:0] idx);
        case (idx)
            IDX_W'(BTN_1U), IDX_W'(BTN_2U), IDX_W'(BTN_3U): call_is_up = 1'b1;
            default:                                        call_is_up = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lift_call_select.sv
// Combinational SCAN picker: chooses the next hall call from the pending set
// given the tracked floor and travel direction.
module lift_call_select
    import lift_pkg::*;
(
    input  logic [NUM_CALLS-1:0] pending,
    input  logic [FLOOR_W-1:0]   cur_floor,
    input  logic                 dir_up,
    output logic                 sel_valid,
    output logic [IDX_W-1:0]     sel_idx,
    output logic [CODE_W-1:0]    sel_code,
    output logic [FLOOR_W-1:0]   sel_floor,
    output logic                 sel_dir_up
);

    logic [NUM_CALLS-1:0] up_ok;
    logic [NUM_CALLS-1:0] dn_ok;
    logic [NUM_CALLS-1:0] u_all;
    logic [NUM_CALLS-1:0] d_all;

    // Within one direction, index order matches floor order, so lowest index = lowest floor.
    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_CALLS-1:0] m);
        lowest = '0;
        for (int i = int'(NUM_CALLS) - 1; i >= 0; i--) begin
            if (m[i]) lowest = IDX_W'(i);
        end
    endfunction

    function automatic logic [IDX_W-1:0] highest(input logic [NUM_CALLS-1:0] m);
        highest = '0;
        for (int i = 0; i < int'(NUM_CALLS); i++) begin
            if (m[i]) highest = IDX_W'(i);
        end
    endfunction

    always_comb begin
        up_ok = '0;
        dn_ok = '0;
        for (int i = 0; i < int'(NUM_CALLS); i++) begin
            up_ok[i] = pending[i] & UP_CALLS[i] & (call_floor(IDX_W'(i)) >= cur_floor);
            dn_ok[i] = pending[i] & DN_CALLS[i] & (call_floor(IDX_W'(i)) <= cur_floor);
        end
    end

    assign u_all = pending & UP_CALLS;
    assign d_all = pending & DN_CALLS;

    // Same-direction pass first, then the opposite pass, then the fallback sweep.
    always_comb begin
        sel_idx = '0;
        if (dir_up) begin
            if (|up_ok)      sel_idx = lowest(up_ok);
            else if (|dn_ok) sel_idx = highest(dn_ok);
            else if (|d_all) sel_idx = highest(d_all);
            else             sel_idx = lowest(u_all);
        end else begin
            if (|dn_ok)      sel_idx = highest(dn_ok);
            else if (|up_ok) sel_idx = lowest(up_ok);
            else if (|u_all) sel_idx = lowest(u_all);
            else             sel_idx = highest(d_all);
        end
    end

    assign sel_valid  = |pending;
    assign sel_code   = call_code(sel_idx);
    assign sel_floor  = call_dest(sel_idx);
    assign sel_dir_up = call_is_up(sel_idx);

endmodule

// File: rtl/lift_call_scheduler.sv
// Hall-call queue in front of the lift FSM: latches sticky calls, tracks floor
// and direction, and issues one SCAN-selected request per handshake round.
module lift_call_scheduler
    import lift_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CALLS-1:0] btn,
    input  logic                 lift_done,
    output logic [CODE_W-1:0]    req_code,
    output logic                 q_empty,
    output logic [NUM_CALLS-1:0] pending,
    output logic [FLOOR_W-1:0]   cur_floor,
    output logic                 dir_up
);

    sched_state_e         state_q, state_d;
    logic [NUM_CALLS-1:0] pending_q, pending_d;
    logic [CODE_W-1:0]    req_code_q, req_code_d;
    logic [FLOOR_W-1:0]   cur_floor_q, cur_floor_d;
    logic                 dir_up_q, dir_up_d;
    logic [NUM_CALLS-1:0] clr;

    logic                 sel_valid;
    logic [IDX_W-1:0]     sel_idx;
    logic [CODE_W-1:0]    sel_code;
    logic [FLOOR_W-1:0]   sel_floor;
    logic                 sel_dir_up;

    lift_call_select u_select (
        .pending    (pending_q),
        .cur_floor  (cur_floor_q),
        .dir_up     (dir_up_q),
        .sel_valid  (sel_valid),
        .sel_idx    (sel_idx),
        .sel_code   (sel_code),
        .sel_floor  (sel_floor),
        .sel_dir_up (sel_dir_up)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            req_code_q  <= REQ_NONE;
            cur_floor_q <= '0;
            dir_up_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            req_code_q  <= req_code_d;
            cur_floor_q <= cur_floor_d;
            dir_up_q    <= dir_up_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_code_d  = REQ_NONE;
        cur_floor_d = cur_floor_q;
        dir_up_d    = dir_up_q;
        clr         = '0;
        case (state_q)
            S_IDLE: begin
                if (sel_valid && lift_done) begin
                    clr         = NUM_CALLS'(1) << sel_idx;
                    req_code_d  = sel_code;
                    cur_floor_d = sel_floor;
                    dir_up_d    = sel_dir_up;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (lift_done) state_d = S_SETTLE;
                else           req_code_d = req_code_q;
            end
            S_SETTLE: state_d = S_WAIT;
            S_WAIT: begin
                if (lift_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A press landing on the call being cleared keeps it pending.
        pending_d = (pending_q & ~clr) | btn;
    end

    assign req_code  = req_code_q;
    assign pending   = pending_q;
    assign cur_floor = cur_floor_q;
    assign dir_up    = dir_up_q;
    assign q_empty   = (pending_q == '0) && ((state_q == S_IDLE) || (state_q == S_WAIT));

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed plus random bench for lift_call_scheduler, checked every cycle
// against a priority-score reference model of the SCAN scheduler.
module tb_lift_call_scheduler;

    logic       clk;
    logic       rst;
    logic [5:0] btn;
    logic       lift_done;
    logic [2:0] req_code;
    logic       q_empty;
    logic [5:0] pending;
    logic [1:0] cur_floor;
    logic       dir_up;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [5:0] m_pend;
    int         m_floor;
    bit         m_up;
    logic [2:0] m_code;
    bit         m_settle;
    bit         m_wait;

    lift_call_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .lift_done (lift_done),
        .req_code  (req_code),
        .q_empty   (q_empty),
        .pending   (pending),
        .cur_floor (cur_floor),
        .dir_up    (dir_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfl(input int i);
        case (i)
            0: return 0;  1: return 1;  2: return 2;
            3: return 1;  4: return 2;  default: return 3;
        endcase
    endfunction

    function automatic bit cup(input int i);
        return (i < 3);
    endfunction

    function automatic logic [2:0] ccode(input int i);
        case (i)
            0: return 3'b001;  1: return 3'b010;  2: return 3'b011;
            3: return 3'b110;  4: return 3'b111;  default: return 3'b100;
        endcase
    endfunction

    // Rank every pending call by (pass category, sweep order); lowest score wins.
    function automatic int model_pick(input logic [5:0] p, input int fl, input bit up);
        int best = -1;
        int best_score = 1000;
        for (int i = 0; i < 6; i++) begin
            if (p[i]) begin
                int f;
                bit u, in_up, in_dn;
                int cat, score;
                f = cfl(i);
                u = cup(i);
                in_up = u && (f >= fl);
                in_dn = !u && (f <= fl);
                if (up) cat = in_up ? 0 : (in_dn ? 1 : (!u ? 2 : 3));
                else    cat = in_dn ? 0 : (in_up ? 1 : (u ? 2 : 3));
                score = cat * 4 + (u ? f : 3 - f);
                if (score < best_score) begin
                    best_score = score;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_floor = 0; m_up = 1'b1;
        m_code = 3'b000; m_settle = 1'b0; m_wait = 1'b0;
    endtask

    task automatic model_edge();
        logic [5:0] clr;
        int k;
        clr = '0;
        if (m_code != 3'b000) begin
            if (lift_done) begin m_code = 3'b000; m_settle = 1'b1; end
        end else if (m_settle) begin
            m_settle = 1'b0; m_wait = 1'b1;
        end else if (m_wait) begin
            if (lift_done) m_wait = 1'b0;
        end else if (m_pend != 0 && lift_done) begin
            k = model_pick(m_pend, m_floor, m_up);
            m_code  = ccode(k);
            clr     = 6'(1) << k;
            m_floor = cup(k) ? cfl(k) + 1 : cfl(k) - 1;
            m_up    = cup(k);
        end
        m_pend = (m_pend & ~clr) | btn;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("req_code", 8'(req_code), 8'(m_code));
        chk("pending", 8'(pending), 8'(m_pend));
        chk("q_empty", 8'(q_empty), 8'((m_pend == 0) && (m_code == 0) && !m_settle));
        chk("cur_floor", 8'(cur_floor), 8'(m_floor));
        chk("dir_up", 8'(dir_up), 8'(m_up));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check_all();
    endtask

    // Step until a request code appears (bounded); returns it and the cycles taken.
    task automatic wait_code(output logic [2:0] code, output int cyc);
        code = 3'b000;
        cyc  = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            cyc++;
            if (req_code != 3'b000) begin
                code = req_code;
                break;
            end
        end
    endtask

    logic [2:0] code;
    int         gap;

    initial begin
        rst = 1'b1; btn = '0; lift_done = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) step();
        rst = 1'b0;
        lift_done = 1'b1;

        // Idle, no buttons.
        repeat (20) begin
            step();
            chk("idle_q_empty", 8'(q_empty), 8'd1);
            chk("idle_req", 8'(req_code), 8'd0);
        end
        chk("idle_floor", 8'(cur_floor), 8'd0);

        // Single 3U call.
        btn = 6'b000100; step(); btn = '0;
        wait_code(code, gap);
        chk("3u_code", 8'(code), 8'b011);
        step();
        chk("3u_one_cycle", 8'(req_code), 8'd0);
        chk("3u_pending", 8'(pending), 8'd0);
        chk("3u_floor", 8'(cur_floor), 8'd3);
        chk("3u_dir", 8'(dir_up), 8'd1);
        repeat (4) step();

        // Move to floor index 1 heading up, then 1U+4D together.
        btn = 6'b000001; step(); btn = '0;
        wait_code(code, gap);
        chk("1u_code", 8'(code), 8'b001);
        repeat (5) step();
        chk("f1_floor", 8'(cur_floor), 8'd1);
        chk("f1_dir", 8'(dir_up), 8'd1);
        btn = 6'b100001; step(); btn = '0;
        wait_code(code, gap);
        chk("fallback_first_4d", 8'(code), 8'b100);
        wait_code(code, gap);
        chk("fallback_then_1u", 8'(code), 8'b001);
        chk("fallback_gap_ge3", 8'(gap >= 3), 8'd1);
        repeat (5) step();

        // lift_done low holds a pending 2D back.
        lift_done = 1'b0;
        btn = 6'b001000; step(); btn = '0;
        repeat (5) begin
            step();
            chk("hold_req", 8'(req_code), 8'd0);
            chk("hold_q_empty", 8'(q_empty), 8'd0);
        end
        lift_done = 1'b1;
        step();
        chk("hold_release_2d", 8'(req_code), 8'b110);
        repeat (5) step();

        // 2U pressed again in the same cycle it is cleared.
        btn = 6'b000010; step(); step(); btn = '0;
        chk("reissue_code", 8'(req_code), 8'b010);
        chk("reissue_sticky", 8'(pending[1]), 8'd1);
        wait_code(code, gap);
        chk("reissue_second", 8'(code), 8'b010);
        repeat (5) step();

        // Reset during ISSUE with 3D presented.
        btn = 6'b010000; step(); btn = '0;
        step();
        lift_done = 1'b0;
        repeat (3) step();
        chk("pre_rst_3d", 8'(req_code), 8'b111);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_req", 8'(req_code), 8'd0);
        chk("rst_pending", 8'(pending), 8'd0);
        check_all();
        repeat (2) step();
        rst = 1'b0;
        lift_done = 1'b1;

        // Random traffic against the model.
        repeat (500) begin
            btn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'b0;
            lift_done = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
